// File: rtl/shift_sequencer8_pkg.sv
// ----------------------------------------------------------------------------
// shift_sequencer8_pkg
// Shared definitions for the 8-bit shift sequencer and its shifter8 datapath:
//   - datapath op codes (NOP, LOAD, LSL, LSR, ASR)
//   - command encodings seen on the sequencer's cmd input
//   - FSM state encodings
//   - maximum distance of a single datapath step
//   - helpers that split a remaining distance into a step and map a command
//     onto a datapath op
// ----------------------------------------------------------------------------
package shift_sequencer8_pkg;

    // Datapath op codes driven onto shifter8.op
    localparam logic [2:0] OP_NOP  = 3'b000;
    localparam logic [2:0] OP_LOAD = 3'b001;
    localparam logic [2:0] OP_LSL  = 3'b010;
    localparam logic [2:0] OP_LSR  = 3'b011;
    localparam logic [2:0] OP_ASR  = 3'b100;

    // Command encodings on the sequencer cmd input
    localparam logic [1:0] CMD_LSL  = 2'b00;
    localparam logic [1:0] CMD_LSR  = 2'b01;
    localparam logic [1:0] CMD_ASR  = 2'b10;
    localparam logic [1:0] CMD_RSVD = 2'b11;

    // FSM state encodings
    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_LOAD  = 2'b01;
    localparam logic [1:0] ST_SHIFT = 2'b10;
    localparam logic [1:0] ST_DONE  = 2'b11;

    // Largest distance the 2-bit shamt can express in one step
    localparam logic [2:0] SHAMT_MAX = 3'd3;

    // Distance of the next step: min(rem, SHAMT_MAX)
    function automatic logic [1:0] step_of(input logic [2:0] rem);
        logic [1:0] step;
        if (rem >= SHAMT_MAX) begin
            step = 2'd3;
        end else begin
            step = rem[1:0];
        end
        return step;
    endfunction

    // Datapath op that implements one step of the given command
    function automatic logic [2:0] shift_op_of(input logic [1:0] cmd);
        logic [2:0] op;
        case (cmd)
            CMD_LSL: op = OP_LSL;
            CMD_LSR: op = OP_LSR;
            CMD_ASR: op = OP_ASR;
            default: op = OP_NOP;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/shift_sequencer8_shifter8.sv
// ----------------------------------------------------------------------------
// shifter8
// 8-bit registered shifter datapath. Each cycle it applies one op to its
// output register: hold, load from d_in, or shift by shamt (0-3 positions).
// Ports:
//   clk      in  1  clock, rising edge
//   reset_n  in  1  asynchronous active-low reset, clears d_out
//   op       in  3  datapath op (see shift_sequencer8_pkg OP_*)
//   shamt    in  2  shift distance for shift ops
//   d_in     in  8  load operand
//   d_out    out 8  registered result
// ----------------------------------------------------------------------------
module shifter8
    import shift_sequencer8_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic [2:0] op,
    input  logic [1:0] shamt,
    input  logic [7:0] d_in,
    output logic [7:0] d_out
);

    logic [7:0] d_out_q;
    logic [7:0] d_out_d;

    // Next datapath value selected by the current op
    always_comb begin
        d_out_d = d_out_q;
        case (op)
            OP_NOP:  d_out_d = d_out_q;
            OP_LOAD: d_out_d = d_in;
            OP_LSL:  d_out_d = d_out_q << shamt;
            OP_LSR:  d_out_d = d_out_q >> shamt;
            OP_ASR:  d_out_d = $unsigned($signed(d_out_q) >>> shamt);
            default: d_out_d = d_out_q;
        endcase
    end

    // Datapath output register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            d_out_q <= 8'h00;
        end else begin
            d_out_q <= d_out_d;
        end
    end

    assign d_out = d_out_q;

endmodule

// File: rtl/shift_sequencer8.sv
// ----------------------------------------------------------------------------
// shift_sequencer8
// Accepts one shift command of 0-7 positions and drives its shifter8 through
// a LOAD step followed by up to three shift steps of at most 3 positions.
// The result comes back with a one-cycle done pulse.
// Ports:
//   clk      in  1  clock, rising edge
//   reset    in  1  asynchronous active-high reset
//   start    in  1  command strobe, sampled only when idle
//   cmd      in  2  00 LSL, 01 LSR, 10 ASR, 11 reserved
//   amt      in  3  shift distance 0-7
//   data_in  in  8  operand
//   busy     out 1  command in flight
//   done     out 1  one-cycle pulse, result/err valid
//   err      out 1  reserved command reported with done
//   result   out 8  last completed result, held until next done
// ----------------------------------------------------------------------------
module shift_sequencer8
    import shift_sequencer8_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [1:0] cmd,
    input  logic [2:0] amt,
    input  logic [7:0] data_in,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [7:0] result
);

    logic [1:0] state_q,  state_d;
    logic [1:0] cmd_q,    cmd_d;
    logic [2:0] rem_q,    rem_d;
    logic [7:0] data_q,   data_d;
    logic [2:0] op_q,     op_d;
    logic [1:0] shamt_q,  shamt_d;
    logic [7:0] result_q, result_d;
    logic       err_q,    err_d;
    logic       done_q,   done_d;
    logic       busy_q,   busy_d;

    logic [1:0] step_s;
    logic [7:0] d_out_s;
    logic       reset_n_s;

    assign step_s    = step_of(rem_q);
    assign reset_n_s = ~reset;

    // Sequencing: the op/shamt for a state are computed on entry so that the
    // registered value is presented to the datapath throughout that state.
    always_comb begin
        state_d  = state_q;
        cmd_d    = cmd_q;
        rem_d    = rem_q;
        data_d   = data_q;
        op_d     = OP_NOP;
        shamt_d  = 2'd0;
        result_d = result_q;
        err_d    = err_q;
        done_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_LOAD;
                    cmd_d   = cmd;
                    rem_d   = amt;
                    data_d  = data_in;
                    op_d    = OP_LOAD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if ((rem_q != 3'd0) && (cmd_q != CMD_RSVD)) begin
                    state_d = ST_SHIFT;
                    op_d    = shift_op_of(cmd_q);
                    shamt_d = step_s;
                    rem_d   = rem_q - {1'b0, step_s};
                end else begin
                    state_d = ST_DONE;
                end
            end
            ST_SHIFT: begin
                // rem_q already accounts for the step being executed now
                if (rem_q == 3'd0) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_SHIFT;
                    op_d    = shift_op_of(cmd_q);
                    shamt_d = step_s;
                    rem_d   = rem_q - {1'b0, step_s};
                end
            end
            ST_DONE: begin
                state_d  = ST_IDLE;
                result_d = d_out_s;
                err_d    = (cmd_q == CMD_RSVD);
                done_d   = 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // Sequencer state, latched operands and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            cmd_q    <= 2'b00;
            rem_q    <= 3'd0;
            data_q   <= 8'h00;
            op_q     <= OP_NOP;
            shamt_q  <= 2'd0;
            result_q <= 8'h00;
            err_q    <= 1'b0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cmd_q    <= cmd_d;
            rem_q    <= rem_d;
            data_q   <= data_d;
            op_q     <= op_d;
            shamt_q  <= shamt_d;
            result_q <= result_d;
            err_q    <= err_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
        end
    end

    shifter8 u_shifter8 (
        .clk     (clk),
        .reset_n (reset_n_s),
        .op      (op_q),
        .shamt   (shamt_q),
        .d_in    (data_q),
        .d_out   (d_out_s)
    );

    assign busy   = busy_q;
    assign done   = done_q;
    assign err    = err_q;
    assign result = result_q;

endmodule

// File: tb/tb_shift_sequencer8.sv
module tb_shift_sequencer8;

    logic       clk;
    logic       reset;
    logic       start;
    logic [1:0] cmd;
    logic [2:0] amt;
    logic [7:0] data_in;
    logic       busy;
    logic       done;
    logic       err;
    logic [7:0] result;

    int total;
    int bad;
    logic [7:0] last_result;
    logic       last_err;

    shift_sequencer8 dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .cmd     (cmd),
        .amt     (amt),
        .data_in (data_in),
        .busy    (busy),
        .done    (done),
        .err     (err),
        .result  (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: the whole shift done in one arithmetic operation
    function automatic logic [7:0] ref_result(input logic [1:0] c, input logic [2:0] a,
                                              input logic [7:0] d);
        logic signed [7:0] s;
        logic [7:0] r;
        s = d;
        case (c)
            2'b00:   r = d << a;
            2'b01:   r = d >> a;
            2'b10:   r = s >>> a;
            default: r = d;
        endcase
        return r;
    endfunction

    function automatic int ref_latency(input logic [1:0] c, input logic [2:0] a);
        int k;
        if (c == 2'b11) k = 0;
        else k = (int'(a) + 2) / 3;
        return 2 + k;
    endfunction

    // Present a command and clock it in (E0); returns 1 time unit after E0
    task automatic issue(input logic [1:0] c, input logic [2:0] a, input logic [7:0] d);
        start = 1'b1;
        cmd = c;
        amt = a;
        data_in = d;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Follow a command until done; optionally pulse start at cycle pulse_at
    task automatic wait_done(input logic [1:0] c, input logic [2:0] a, input logic [7:0] d,
                             input int pulse_at, input string name);
        int n;
        bit seen;
        int lat;
        logic [7:0] exp_r;
        n = 0;
        seen = 1'b0;
        lat = ref_latency(c, a);
        exp_r = ref_result(c, a, d);
        while (!seen && n < 20) begin
            start = (n == pulse_at);
            cmd = 2'($urandom);
            amt = 3'($urandom);
            data_in = 8'($urandom);
            @(posedge clk);
            #1;
            start = 1'b0;
            n++;
            if (done === 1'b1) begin
                seen = 1'b1;
            end else begin
                total++;
                if (busy !== 1'b1) begin
                    bad++;
                    $display("FAIL %s busy cycle %0d: got %b want 1", name, n, busy);
                end
            end
        end
        total++;
        if (!seen) begin
            bad++;
            $display("FAIL %s timeout: no done within %0d cycles, want %0d", name, n, lat);
        end else begin
            if (n != lat) begin
                bad++;
                $display("FAIL %s latency: got %0d want %0d", name, n, lat);
            end
            total++;
            if (result !== exp_r) begin
                bad++;
                $display("FAIL %s result: got %h want %h", name, result, exp_r);
            end
            total++;
            if (err !== (c == 2'b11)) begin
                bad++;
                $display("FAIL %s err: got %b want %b", name, err, (c == 2'b11));
            end
            total++;
            if (busy !== 1'b0) begin
                bad++;
                $display("FAIL %s busy in done cycle: got %b want 0", name, busy);
            end
        end
        last_result = exp_r;
        last_err = (c == 2'b11);
    endtask

    // Idle cycles after done: done must be a single pulse and result held
    task automatic idle_check(input int cycles, input string name);
        for (int g = 0; g < cycles; g++) begin
            start = 1'b0;
            data_in = 8'($urandom);
            @(posedge clk);
            #1;
            total++;
            if (done !== 1'b0 || busy !== 1'b0 || result !== last_result || err !== last_err) begin
                bad++;
                $display("FAIL %s idle: done=%b busy=%b result=%h err=%b want 0 0 %h %b",
                         name, done, busy, result, err, last_result, last_err);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        cmd = 2'b00;
        amt = 3'd0;
        data_in = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0 || result !== 8'h00) begin
            bad++;
            $display("FAIL reset_state: busy=%b done=%b err=%b result=%h want 0 0 0 00",
                     busy, done, err, result);
        end
        reset = 1'b0;
        last_result = 8'h00;
        last_err = 1'b0;
    endtask

    task automatic test_directed();
        logic [1:0] c_tab [5] = '{2'b00, 2'b01, 2'b10, 2'b00, 2'b11};
        logic [2:0] a_tab [5] = '{3'd2, 3'd4, 3'd7, 3'd0, 3'd5};
        logic [7:0] d_tab [5] = '{8'h34, 8'h98, 8'h98, 8'hA5, 8'h3C};
        logic [7:0] r_tab [5] = '{8'hD0, 8'h09, 8'hFF, 8'hA5, 8'h3C};
        for (int i = 0; i < 5; i++) begin
            issue(c_tab[i], a_tab[i], d_tab[i]);
            wait_done(c_tab[i], a_tab[i], d_tab[i], -1, "directed");
            total++;
            if (result !== r_tab[i]) begin
                bad++;
                $display("FAIL directed_const %0d: got %h want %h", i, result, r_tab[i]);
            end
            idle_check(1, "directed");
        end
    endtask

    task automatic test_ignore_busy();
        logic [7:0] d;
        d = 8'($urandom);
        issue(2'b10, 3'd7, d);
        wait_done(2'b10, 3'd7, d, 2, "ignore_busy");
        idle_check(2, "ignore_busy");
    endtask

    task automatic test_back_to_back();
        logic [7:0] d0;
        logic [7:0] d1;
        d0 = 8'($urandom);
        d1 = 8'($urandom);
        issue(2'b01, 3'd5, d0);
        wait_done(2'b01, 3'd5, d0, -1, "b2b_first");
        issue(2'b00, 3'd3, d1);
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL b2b accept: busy got %b want 1", busy);
        end
        wait_done(2'b00, 3'd3, d1, -1, "b2b_second");
        idle_check(1, "b2b");
    endtask

    task automatic test_reset_mid();
        logic [7:0] d;
        d = 8'($urandom);
        issue(2'b00, 3'd7, d);
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0 || result !== 8'h00) begin
            bad++;
            $display("FAIL reset_mid: busy=%b done=%b err=%b result=%h want 0 0 0 00",
                     busy, done, err, result);
        end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            total++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                bad++;
                $display("FAIL reset_hold: done=%b busy=%b want 0 0", done, busy);
            end
        end
        reset = 1'b0;
        last_result = 8'h00;
        last_err = 1'b0;
        d = 8'($urandom);
        issue(2'b01, 3'd6, d);
        wait_done(2'b01, 3'd6, d, -1, "after_reset");
        idle_check(1, "after_reset");
    endtask

    task automatic test_random();
        logic [1:0] c;
        logic [2:0] a;
        logic [7:0] d;
        for (int i = 0; i < 40; i++) begin
            c = 2'($urandom);
            a = 3'($urandom);
            d = 8'($urandom);
            issue(c, a, d);
            wait_done(c, a, d, int'($urandom_range(0, 6)), "random");
            idle_check(int'($urandom_range(0, 2)), "random");
        end
    endtask

    initial begin
        total = 0;
        bad = 0;
        test_reset();
        test_directed();
        test_ignore_busy();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
